chan_select_pipe: RTL
=====================

Name: chan_select_pipe

Overview:
Parametrised N-channel, W-bit stream selector with a registered selection and a one-entry registered output stage.
- Only the selected input channel can transfer to the single output; all other channels are held off.
- Each channel uses a valid/ready handshake.
- Used wherever several producers share one consumer under software- or FSM-controlled channel choice.

Parameters:
NCH, 6, number of input channels (2..16)
WIDTH, 4, data width per channel
SELW, $clog2(NCH) with a minimum of 1, width of the sel input

Ports:
clk  input  1  clock, rising edge
areset_n  input  1  asynchronous active-low reset
sel  input  SELW  requested channel index
sel_load  input  1  load sel into the selection register this cycle
in_data  input  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready
out_data  output  WIDTH  registered output data
out_valid  output  1  output stage holds a word
out_ready  input  1  consumer accepts the word
cur_sel  output  SELW  currently active channel
sel_err  output  1  the active selection is out of range (value >= NCH)

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - cur_sel=0, sel_err=0, out_valid=0, out_data=0.
  - in_ready=0 while areset_n is low.
- Selection register:
  - On a clk edge with sel_load=1: cur_sel<=sel and sel_err<=(sel>=NCH).
  - The new selection takes effect the cycle after the load.
  - A transfer in the same cycle as the load uses the old cur_sel.
- Output stage enable: stage_en = !out_valid || out_ready.
- in_ready:
  - in_ready[cur_sel] = stage_en && !sel_err.
  - All other bits are 0, and all bits are 0 when sel_err=1.
- Accept: accept = in_valid[cur_sel] && in_ready[cur_sel].
- On accept: out_data <= channel cur_sel data, and out_valid<=1. Latency from input handshake to out_valid is 1 cycle.
- On out_ready && out_valid without an accept: out_valid<=0, and out_data holds its last value.
- Simultaneous drain and accept: out_valid stays 1 and out_data takes the new word. This gives full throughput of 1 word per cycle.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_valid are stable and in_ready is all 0.
- Out-of-range selection (sel>=NCH):
  - No new transfers; in_ready is all 0.
  - A word already in the output stage still drains normally.
  - sel_err clears only on a later load of an in-range sel.
- Changing the selection while out_valid=1 is legal; the buffered word still belongs to the old channel and drains unchanged.
- Valid channels with in_valid=1 are never dropped; a producer must hold its data until its ready is seen.
- Reset mid-operation: the buffered word is discarded (out_valid=0) and the selection returns to channel 0.

Optional Feature:
Macro: CHAN_SELECT_PIPE_XFER_CNT_EN.
- Defined:
  - Adds output xfer_cnt [15:0], which counts accepted input words and saturates at 16'hFFFF.
  - Adds input cnt_clr, a synchronous clear of xfer_cnt.
  - Clear wins over increment in the same cycle.
  - Reset value of xfer_cnt is 0.
- Not defined: neither port exists and there is no counter logic; the rest of the behaviour is identical.

Test Plan:
- Reset default: after reset with in_valid=6'b000001 and ch0=4'hA, out_ready=1 → cycle 1: out_valid=1, out_data=4'hA; in_ready=6'b000001.
- Channel switch: load sel=3 while ch0 is streaming, with ch3=4'h5 valid → the load-cycle word comes from ch0; the next cycle's word is 4'h5; cur_sel=3; in_ready=6'b001000.
- Back-pressure: out_ready=0 for 4 cycles with ch2 valid → out_data is stable, out_valid=1, in_ready=0. When out_ready=1, one word drains and a new word is accepted in the same cycle.
- Out-of-range: load sel=6 (or 7) with NCH=6 → sel_err=1, in_ready=0; a pending out word still drains; a later load of sel=1 gives sel_err=0 and transfers resume.
- Throughput: ch4 valid continuously with out_ready=1 → 16 consecutive words in 16 cycles, with no bubbles and no duplicates.
- Mid-operation reset: areset_n low while out_valid=1 → immediately out_valid=0, out_data=0, cur_sel=0. With the macro defined, xfer_cnt reaches 0xFFFF and holds, and cnt_clr returns it to 0.

Source files
------------

// File: rtl/chan_select_pipe.sv
// N-channel valid/ready stream selector: registered channel choice, one-entry output stage.
// Optional transfer counter (xfer_cnt/cnt_clr) enabled by defining CHAN_SELECT_PIPE_XFER_CNT_EN.
module chan_select_pipe #(
  parameter int NCH   = 6,
  parameter int WIDTH = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic [SELW-1:0]      sel,
  input  logic                 sel_load,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      cur_sel,
  output logic                 sel_err
`ifdef CHAN_SELECT_PIPE_XFER_CNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [15:0]          xfer_cnt
`endif
);

  logic [SELW-1:0]  cur_sel_q;
  logic             sel_err_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             stage_en;
  logic             accept;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic [NCH-1:0]   in_ready_d;

  assign stage_en = !out_valid_q || out_ready;

  // Out-of-range selections match no channel, so no indexing beyond NCH occurs.
  always_comb begin
    sel_valid  = 1'b0;
    sel_data   = '0;
    in_ready_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (cur_sel_q == SELW'(c)) begin
        sel_valid     = in_valid[c];
        sel_data      = in_data[c*WIDTH +: WIDTH];
        in_ready_d[c] = stage_en && !sel_err_q && areset_n;
      end
    end
  end

  assign accept = sel_valid && stage_en && !sel_err_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cur_sel_q   <= '0;
      sel_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (sel_load) begin
        cur_sel_q <= sel;
        sel_err_q <= (int'(sel) >= NCH);
      end
      if (accept) begin
        out_data_q  <= sel_data;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_d;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign cur_sel   = cur_sel_q;
  assign sel_err   = sel_err_q;

`ifdef CHAN_SELECT_PIPE_XFER_CNT_EN
  logic [15:0] xfer_cnt_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      xfer_cnt_q <= '0;
    end else if (cnt_clr) begin
      xfer_cnt_q <= '0;
    end else if (accept && (xfer_cnt_q != '1)) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
